rom_display_ctrl: RTL and testbench
===================================

# rom_display_ctrl

Sequencer between the switch bank, the synchronous lookup ROM and the seven-segment digit decoders. It detects a new switch value, issues a ROM read and waits out the ROM latency. It then time-shares one serial shift-add-3 binary-to-BCD converter between the address and the returned data. Both BCD results are presented to the display decoders as one atomic update, replacing the two parallel combinational converters.

## Interface
- `W`, 10: address and data width in bits.
- `DIGITS`, 4: BCD digits per result (must satisfy 10^DIGITS > 2^W − 1).
- `ROM_LAT`, 2: cycles from ROM address change to valid ROM data.
- `CLOCK_50` input, 1: single clock, rising-edge.
- `RESET_N` input, 1: synchronous, active-low reset.
- `SW` input, W: raw switch value (asynchronous to `CLOCK_50`).
- `ROM_Q` input, W: ROM read data.
- `ROM_ADDR` output, W: ROM address (registered).
- `BCD_ADDR` output, 4·DIGITS: BCD of the address currently displayed; the least-significant digit is in bits [3:0].
- `BCD_DATA` output, 4·DIGITS: BCD of the ROM word at `BCD_ADDR`.
- `BUSY` output, 1: high in every state except IDLE.
- `DONE` output, 1: one-cycle pulse in the cycle the new `BCD_*` values first appear.

## Operation
- `SW` passes through a 2-flop synchronizer; only the synchronized value `sw_s` is used.
- A `primed` flag is cleared by reset. While it is clear, IDLE starts a run unconditionally, so ROM[0] is displayed after reset.
- **IDLE:** if `!primed` or `sw_s != ROM_ADDR`, then `ROM_ADDR <= sw_s` and the FSM goes to FETCH. Otherwise it stays in IDLE.
- **FETCH:** counts ROM_LAT cycles. On the last cycle it captures `ROM_Q` into `data_r`, then goes to CONV_A.
- **CONV_A:** W cycles of serial double-dabble on `ROM_ADDR`. The result goes into `addr_bcd_r`, then the FSM goes to CONV_D.
- **CONV_D:** W cycles of double-dabble on `data_r`. The result goes into `data_bcd_r`, then the FSM goes to UPDATE.
- **UPDATE:** one cycle. `BCD_ADDR <= addr_bcd_r`, `BCD_DATA <= data_bcd_r`, `DONE <= 1`, `primed <= 1`, then the FSM returns to IDLE.
- Double-dabble step:
  - Each digit ≥ 5 gets +3.
  - The digit register then shifts left by 1, taking in the binary MSB.
  - The binary operand shifts left.
  - After exactly W steps the result is final; there is no extra correction cycle.
- The converter is cleared at the start of each conversion, with no carry-over between operands.
- Mid-run switch changes: `sw_s` is ignored outside IDLE, and the run in progress completes with its latched address. If `sw_s` differs from `ROM_ADDR` on return to IDLE, the next run starts on that IDLE cycle. There are no back-to-back idle bubbles beyond that one cycle.
- `ROM_ADDR` is held constant from FETCH through UPDATE.
- `BCD_ADDR` and `BCD_DATA` always form a consistent pair; they never change in different cycles.
- Reset, at any edge with `RESET_N=0` and including mid-conversion:
  - FSM goes to IDLE; `ROM_ADDR=0`, `BCD_ADDR=0`, `BCD_DATA=0`.
  - `BUSY=0`, `DONE=0`, `primed=0`.
  - Synchronizer flops and converter registers are 0.
  - Any partial result is discarded.

## Timing
- Edge numbering: e0 is the edge at which IDLE launches a run.
- FETCH occupies e1..e(ROM_LAT); `ROM_Q` is sampled at e(ROM_LAT).
- CONV_A runs to e(ROM_LAT+W), and CONV_D runs to e(ROM_LAT+2W).
- The UPDATE edge is e(ROM_LAT+2W+1). `BCD_*` change and `DONE` rises at that edge; this is e23 for the defaults.
- `BUSY` rises at e0 and falls at e(ROM_LAT+2W+1).
- Switch-to-launch latency is 2 synchronizer edges plus 1 compare edge.
- Minimum run period is ROM_LAT+2W+2 cycles (24 cycles for the defaults).

## Structure
- Shared package `rom_disp_pkg`:
  - FSM state encodings (IDLE, FETCH, CONV_A, CONV_D, UPDATE).
  - Default `W`, `DIGITS` and `ROM_LAT` constants.
- Sub-module `bcd_serial_conv`:
  - Parameters `W`, `DIGITS`.
  - Inputs: `CLOCK_50`, `RESET_N`, `start`, `bin[W-1:0]`.
  - Outputs: `bcd[4·DIGITS-1:0]`, `done`.
  - `done` pulses after W cycles.
  - Instantiated once and shared by CONV_A and CONV_D.
- The top controller holds the FSM, latency counter, synchronizer and output registers.

## Test plan
- **Reset priming:** ROM model with ROM[0]=7, `SW=0`; release reset.
  - Required: `DONE` at cycle 24 (23 + 1 compare), `BCD_ADDR=0x0000`, `BCD_DATA=0x0007`.
- **Single lookup:** `SW=5`, ROM[5]=123.
  - Required: `ROM_ADDR=5` is held through the run.
  - Required: `BCD_ADDR=0x0005`, `BCD_DATA=0x0123`, `DONE` 23 edges after launch.
- **Width extremes:** `SW=1023`, ROM[1023]=1000.
  - Required: `BCD_ADDR=0x1023`, `BCD_DATA=0x1000`.
  - Repeat with ROM[n]=0 → `BCD_DATA=0x0000`.
- **Mid-run change:** `SW` changes 5→9 at e10.
  - Required: the first `DONE` shows 5 / ROM[5].
  - Required: a second run launches the cycle after returning to IDLE, and its `DONE` shows 9 / ROM[9].
  - Required: no pair mixing in either update.
- **Reset mid-run:** `RESET_N=0` at e12 of a run for `SW=300`.
  - Required: outputs are 0 the next cycle and `BUSY=0`.
  - Required: after release, a primed run produces `BCD_ADDR=0x0300` with no stale data.
- **Stable input:** `SW` held constant for 1000 cycles after a completed run.
  - Required: no further `DONE`, `BUSY` stays 0, `ROM_ADDR` unchanged.

Source files
------------

// File: rtl/rom_disp_pkg.sv
// Shared types and defaults for the ROM display sequencer.
package rom_disp_pkg;
  localparam int DEF_W       = 10;
  localparam int DEF_DIGITS  = 4;
  localparam int DEF_ROM_LAT = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CONV_A,
    S_CONV_D,
    S_UPDATE
  } state_t;
endpackage

// File: rtl/bcd_serial_conv.sv
// Serial shift-add-3 binary-to-BCD converter, one bit per cycle.
// A start cycle performs the first step directly from 'bin' with a cleared
// digit register, so W steps complete in W clock edges with no load cycle.
// 'done' is high during the cycle whose closing edge performs the final step.
module bcd_serial_conv #(
  parameter int W      = 10,
  parameter int DIGITS = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]        sh;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] adj_src;
  logic [4*DIGITS-1:0] adj;
  logic                msb;

  // Add-3 correction on every digit >= 5, taken from a cleared register on start.
  always_comb begin
    adj_src = start ? '0 : bcd;
    msb     = start ? bin[W-1] : sh[W-1];
    adj     = adj_src;
    for (int d = 0; d < DIGITS; d++)
      if (adj_src[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj_src[4*d +: 4] + 4'd3;
  end

  assign done = start ? (W == 1) : (cnt == CW'(1));

  // Shift the corrected digits left, pulling in the operand MSB.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      bcd <= '0;
      sh  <= '0;
      cnt <= '0;
    end else if (start) begin
      bcd <= {adj[4*DIGITS-2:0], msb};
      sh  <= bin << 1;
      cnt <= CW'(W - 1);
    end else if (cnt != '0) begin
      bcd <= {adj[4*DIGITS-2:0], msb};
      sh  <= sh << 1;
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/rom_display_ctrl.sv
// Sequencer: switch sync -> ROM fetch -> shared serial BCD conversion of the
// address and then the data -> atomic update of both display pairs.
import rom_disp_pkg::*;

module rom_display_ctrl #(
  parameter int W       = DEF_W,
  parameter int DIGITS  = DEF_DIGITS,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [W-1:0]        SW,
  input  logic [W-1:0]        ROM_Q,
  output logic [W-1:0]        ROM_ADDR,
  output logic [4*DIGITS-1:0] BCD_ADDR,
  output logic [4*DIGITS-1:0] BCD_DATA,
  output logic                BUSY,
  output logic                DONE
);
  localparam int LW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  state_t              state;
  logic [W-1:0]        sw_m, sw_s;
  logic                primed;
  logic [LW-1:0]       lat_cnt;
  logic [W-1:0]        data_r;
  logic [4*DIGITS-1:0] addr_bcd_r;
  logic                first;
  logic [W-1:0]        conv_bin;
  logic [4*DIGITS-1:0] conv_bcd;
  logic                conv_done;

  // Two-flop synchronizer for the asynchronous switch bank.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      sw_m <= SW;
      sw_s <= sw_m;
    end
  end

  // The operand is only consumed on the start cycle of each conversion.
  assign conv_bin = (state == S_CONV_A) ? ROM_ADDR : data_r;

  bcd_serial_conv #(.W(W), .DIGITS(DIGITS)) u_conv (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .start    (first),
    .bin      (conv_bin),
    .bcd      (conv_bcd),
    .done     (conv_done)
  );

  // Main FSM. The converter's own digit register holds the data result until
  // UPDATE, so the data BCD goes straight from it to BCD_DATA.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      ROM_ADDR   <= '0;
      BCD_ADDR   <= '0;
      BCD_DATA   <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      primed     <= 1'b0;
      lat_cnt    <= '0;
      data_r     <= '0;
      addr_bcd_r <= '0;
      first      <= 1'b0;
    end else begin
      DONE  <= 1'b0;
      first <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!primed || sw_s != ROM_ADDR) begin
            ROM_ADDR <= sw_s;
            BUSY     <= 1'b1;
            lat_cnt  <= '0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (lat_cnt == LW'(ROM_LAT - 1)) begin
            data_r <= ROM_Q;
            first  <= 1'b1;
            state  <= S_CONV_A;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        S_CONV_A: begin
          if (conv_done) begin
            first <= 1'b1;
            state <= S_CONV_D;
          end
        end
        S_CONV_D: begin
          // Address result is still intact during the data start cycle.
          if (first) addr_bcd_r <= conv_bcd;
          if (conv_done) state <= S_UPDATE;
        end
        S_UPDATE: begin
          BCD_ADDR <= addr_bcd_r;
          BCD_DATA <= conv_bcd;
          DONE     <= 1'b1;
          primed   <= 1'b1;
          BUSY     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_display_ctrl.sv
// Randomized + directed bench for rom_display_ctrl against a decimal model.
module tb_rom_display_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  sw;
  logic [9:0]  rom_q;
  logic [9:0]  rom_addr;
  logic [15:0] bcd_addr, bcd_data;
  logic        busy, done;

  logic [9:0]  rom_mem [1024];
  int          n_chk = 0;
  int          n_err = 0;
  int          bad_change = 0;
  logic [31:0] prev_pair = '0;

  always #5 clk = ~clk;

  rom_display_ctrl dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .SW       (sw),
    .ROM_Q    (rom_q),
    .ROM_ADDR (rom_addr),
    .BCD_ADDR (bcd_addr),
    .BCD_DATA (bcd_data),
    .BUSY     (busy),
    .DONE     (done)
  );

  // Synchronous ROM: data valid one edge after the address, well inside ROM_LAT.
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  // Displayed pair may change only together with DONE (or under reset).
  always begin
    @(negedge clk);
    #1;
    if ({bcd_addr, bcd_data} != prev_pair && !done && rst_n) bad_change++;
    prev_pair = {bcd_addr, bcd_data};
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits for a launch, then checks latency, address hold and the final pair.
  task automatic expect_run(input string tag, input logic [9:0] a);
    int t;
    bit held;
    t = 0;
    while (!busy && t < 60) begin @(negedge clk); t++; end
    chk({tag, "_launch"}, 32'(t < 60), 1);
    chk({tag, "_addr"}, rom_addr, a);
    held = 1;
    t = 0;
    while (!done && t < 60) begin
      @(negedge clk);
      t++;
      if (rom_addr != a) held = 0;
    end
    chk({tag, "_lat"}, t, 23);
    chk({tag, "_held"}, held, 1);
    chk({tag, "_bcda"}, bcd_addr, to_bcd(a));
    chk({tag, "_bcdd"}, bcd_data, to_bcd(rom_mem[a]));
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int t;
    int nd, nb;
    logic [9:0] a, cur;

    for (int i = 0; i < 1024; i++) rom_mem[i] = 10'($urandom_range(0, 1023));
    rom_mem[0]    = 10'd7;
    rom_mem[5]    = 10'd123;
    rom_mem[1023] = 10'd1000;
    rom_mem[300]  = 10'd999;
    rst_n = 1'b0;
    sw    = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_bcda", bcd_addr, 0);
    chk("rst_bcdd", bcd_data, 0);

    // Reset priming: ROM[0] appears 24 edges after release.
    rst_n = 1'b1;
    t = 0;
    while (!done && t < 60) begin @(negedge clk); t++; end
    chk("prime_lat", t, 24);
    chk("prime_bcda", bcd_addr, 16'h0000);
    chk("prime_bcdd", bcd_data, 16'h0007);

    // Single lookup and width extremes.
    sw = 10'd5;     expect_run("single", 10'd5);
    chk("single_val", bcd_data, 16'h0123);
    sw = 10'd1023;  expect_run("max", 10'd1023);
    chk("max_val", {bcd_addr, bcd_data}, 32'h1023_1000);
    sw = 10'd1022;  expect_run("max_m1", 10'd1022);
    rom_mem[1023] = 10'd0;
    sw = 10'd1023;  expect_run("zero", 10'd1023);
    chk("zero_val", bcd_data, 16'h0000);

    // Mid-run change 5 -> 9: first run completes, second launches right after.
    sw = 10'd5;
    t = 0;
    while (!busy && t < 60) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    sw = 10'd9;
    t = 0;
    while (!done && t < 60) begin @(negedge clk); t++; end
    chk("mid1_bcda", bcd_addr, to_bcd(5));
    chk("mid1_bcdd", bcd_data, to_bcd(rom_mem[5]));
    @(negedge clk);
    chk("mid2_relaunch", busy, 1);
    expect_run("mid2", 10'd9);

    // Reset in the middle of a run for address 300.
    sw = 10'd300;
    t = 0;
    while (!busy && t < 60) begin @(negedge clk); t++; end
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_addr", rom_addr, 0);
    chk("mrst_pair", {bcd_addr, bcd_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_run("mrst_p0", 10'd0);
    expect_run("mrst_p300", 10'd300);

    // Random lookups.
    cur = 10'd300;
    for (int k = 0; k < 16; k++) begin
      a = 10'($urandom_range(0, 1023));
      if (a == cur) a = a ^ 10'd1;
      sw = a;
      expect_run("rand", a);
      cur = a;
    end

    // Stable input: nothing happens for 1000 cycles.
    nd = 0;
    nb = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    chk("stable_done", nd, 0);
    chk("stable_busy", nb, 0);
    chk("stable_addr", rom_addr, cur);
    chk("atomic_pair", bad_change, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
